// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the load/store path.
// Accepts one word request at a time over a valid/ready handshake, waits
// WAIT cycles, then answers with a one-cycle response (load data or a store
// acknowledge) and an error flag for misaligned or out-of-range accesses.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   req_valid  request present
//   req_ready  responder idle and able to accept
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load data (0 for stores and errors), held between responses
//   rsp_err    misaligned / out-of-range, held between responses
//   busy       a request is in flight
//
// State | meaning
// IDLE  | ready for a request; accept latches write/index/data/err
// WAIT  | counting down wait states
// RESP  | rsp_valid high for one cycle; a store commits on the closing edge

module dmem_responder #(
  parameter int          AW_WORDS = 10,
  parameter int          WAIT     = 2,
  parameter logic [31:0] BASE     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          DEPTH     = 1 << AW_WORDS;
  localparam logic [3:0]  WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  state_t state, state_next;
  logic [3:0] cnt;

  logic                write_q;
  logic                err_q;
  logic [AW_WORDS-1:0] idx_q;
  logic [31:0]         wdata_q;

  logic [31:0]         req_offset;
  logic [AW_WORDS-1:0] req_idx;
  logic                req_err;
  logic                accept;

  logic                src_write;
  logic                src_err;
  logic [AW_WORDS-1:0] src_idx;

  // Addresses below BASE wrap to huge offsets and fail the range test.
  assign req_offset = req_addr - BASE;
  assign req_idx    = req_offset[AW_WORDS+1:2];
  assign req_err    = (req_offset[1:0] != 2'b00) ||
                      ((req_offset >> (AW_WORDS + 2)) != 32'd0);

  assign accept = req_valid && (state == S_IDLE);

  // With no wait states RESP is entered on the accept edge itself, so the
  // response source must come straight from the request inputs.
  assign src_write = (state == S_IDLE) ? req_write : write_q;
  assign src_err   = (state == S_IDLE) ? req_err   : err_q;
  assign src_idx   = (state == S_IDLE) ? req_idx   : idx_q;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = (WAIT > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        cnt     <= WAIT_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Memory only changes on a RESP edge of this single in-flight request,
      // so reading it on the edge that enters RESP gives the committed value.
      if (state_next == S_RESP && state != S_RESP) begin
        rsp_err   <= src_err;
        rsp_rdata <= (src_write || src_err) ? 32'd0 : mem[src_idx];
      end
    end
  end

  // Storage is not reset; a reset on the RESP edge drops the store.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && write_q && !err_q)
      mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [4];
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_write [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic        rsp_valid [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];
  logic        busy      [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = cyc + 1;

  // u0: WAIT=2 BASE=0; u1: WAIT=0; u2: BASE=0x1000 AW=4; u3: WAIT=5
  dmem_responder #(.AW_WORDS(10), .WAIT(2), .BASE(32'h0)) u0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));
  dmem_responder #(.AW_WORDS(10), .WAIT(0), .BASE(32'h0)) u1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));
  dmem_responder #(.AW_WORDS(4), .WAIT(2), .BASE(32'h1000)) u2 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));
  dmem_responder #(.AW_WORDS(10), .WAIT(5), .BASE(32'h0)) u3 (
    .clk(clk), .reset(reset[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_write(req_write[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3]),
    .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .rsp_err(rsp_err[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues one request, then watches negedges after the
  // accept edge until req_ready returns. lat = negedge index of rsp_valid
  // (1 = first negedge after accept), rlow = negedges with req_ready low.
  task automatic xact(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic hold,
                      input logic [31:0] hold_addr,
                      output int lat, output int rlow, output logic [31:0] rd,
                      output logic er, output int acc);
    int n;
    int pulses;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_before_accept u%0d", d), 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (hold) req_addr[d] = hold_addr;
    else      req_valid[d] = 1'b0;
    lat = 0; rlow = 0; rd = '0; er = 1'b0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid[d]) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          rd  = rsp_rdata[d];
          er  = rsp_err[d];
        end
      end
      if (req_ready[d]) break;
      rlow++;
    end
    chk($sformatf("rsp_pulses u%0d a=%h", d, addr), 32'(pulses), 32'd1);
  endtask

  int          lat, rlow, acc, acc_prev;
  logic [31:0] rd;
  logic        er;
  int          pulses;

  initial begin
    for (int d = 0; d < 4; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset req_ready u%0d", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("reset rsp_valid u%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("reset rsp_rdata u%0d", d), rsp_rdata[d], 32'd0);
      chk($sformatf("reset rsp_err u%0d", d), 32'(rsp_err[d]), 32'd0);
      chk($sformatf("reset busy u%0d", d), 32'(busy[d]), 32'd0);
      reset[d] = 1'b0;
    end
    @(negedge clk);

    // ---- u0: WAIT=2 ----
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("w2 store lat", 32'(lat), 32'd3);
    chk("w2 store ready_low", 32'(rlow), 32'd3);
    chk("w2 store rdata", rd, 32'd0);
    chk("w2 store err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("w2 load lat", 32'(lat), 32'd3);
    chk("w2 load ready_low", 32'(rlow), 32'd3);
    chk("w2 load rdata", rd, 32'hDEADBEEF);
    chk("w2 load err", 32'(er), 32'd0);
    chk("w2 rdata held", rsp_rdata[0], 32'hDEADBEEF);
    chk("w2 valid low after", 32'(rsp_valid[0]), 32'd0);
    xact(0, 1'b1, 32'h12, 32'hFFFF_FFFF, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("misaligned store err", 32'(er), 32'd1);
    chk("misaligned store rdata", rd, 32'd0);
    chk("err held", 32'(rsp_err[0]), 32'd1);
    xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("after misaligned rdata", rd, 32'hDEADBEEF);
    chk("after misaligned err", 32'(er), 32'd0);
    xact(0, 1'b1, 32'h14, 32'h1234_5678, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("store 0x14 err", 32'(er), 32'd0);
    // Hold req_valid and move the address while the request is in flight.
    xact(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h14, lat, rlow, rd, er, acc_prev);
    chk("hold rdata latched", rd, 32'hDEADBEEF);
    chk("hold lat", 32'(lat), 32'd3);
    xact(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("hold second rdata", rd, 32'h1234_5678);
    chk("hold accept spacing", 32'(acc - acc_prev), 32'd4);

    // ---- u1: WAIT=0 back to back ----
    acc_prev = 0;
    for (int i = 0; i < 8; i++) begin
      xact(1, (i < 4), 32'(4 * (i % 4)), 32'(i % 4 + 1), 1'b0, 32'h0, lat, rlow, rd, er, acc);
      chk($sformatf("w0 lat #%0d", i), 32'(lat), 32'd1);
      chk($sformatf("w0 err #%0d", i), 32'(er), 32'd0);
      chk($sformatf("w0 rdata #%0d", i), rd, (i < 4) ? 32'd0 : 32'(i - 3));
      if (i > 0) chk($sformatf("w0 spacing #%0d", i), 32'(acc - acc_prev), 32'd2);
      acc_prev = acc;
    end
    // Reset together with req_valid: reset wins, nothing accepted.
    reset[1] = 1'b1; req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0;
    @(negedge clk);
    chk("rst+valid busy", 32'(busy[1]), 32'd0);
    chk("rst+valid rdata cleared", rsp_rdata[1], 32'd0);
    reset[1] = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rst+valid no rsp", 32'(rsp_valid[1]), 32'd0);
    chk("rst+valid idle", 32'(busy[1]), 32'd0);

    // ---- u2: BASE=0x1000, AW_WORDS=4 ----
    xact(2, 1'b1, 32'h103C, 32'hCAFE_0001, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("base store 0x103C err", 32'(er), 32'd0);
    xact(2, 1'b0, 32'h0FFC, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("base load 0x0FFC err", 32'(er), 32'd1);
    chk("base load 0x0FFC rdata", rd, 32'd0);
    xact(2, 1'b0, 32'h1040, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("base load 0x1040 err", 32'(er), 32'd1);
    chk("base load 0x1040 rdata", rd, 32'd0);
    xact(2, 1'b0, 32'h103C, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("base load 0x103C err", 32'(er), 32'd0);
    chk("base load 0x103C rdata", rd, 32'hCAFE_0001);

    // ---- u3: WAIT=5, reset mid-WAIT ----
    xact(3, 1'b1, 32'h20, 32'hAAAA_5555, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("w5 store lat", 32'(lat), 32'd6);
    req_valid[3] = 1'b1; req_write[3] = 1'b1; req_addr[3] = 32'h20; req_wdata[3] = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    req_valid[3] = 1'b0;
    chk("w5 accepted busy", 32'(busy[3]), 32'd1);
    @(negedge clk);
    reset[3] = 1'b1;
    @(negedge clk);
    reset[3] = 1'b0;
    chk("w5 ready after reset", 32'(req_ready[3]), 32'd1);
    chk("w5 busy after reset", 32'(busy[3]), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid[3]) pulses++;
      @(negedge clk);
    end
    chk("w5 no rsp after reset", 32'(pulses), 32'd0);
    xact(3, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, lat, rlow, rd, er, acc);
    chk("w5 store dropped", rd, 32'hAAAA_5555);
    chk("w5 load lat", 32'(lat), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder, the target end of the datapath's load/store interface (MemRead/MemWrite, address, write data).
- Replaces the single-cycle memory behind the DM stage when modelling slower memory.
- Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns read data, or a write acknowledge, with an error flag.
- Storage is an internal word array; addresses are byte addresses, matching the core's PC and ALU outputs.

Parameters:
- AW_WORDS, default 10: log2 of the word count; the array holds 2^AW_WORDS 32-bit words.
- WAIT, default 2: wait-state cycles between accept and response. Legal range is 0..15.
- BASE, default 32'h0000_0000: byte address of word 0.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_write, input, 1: 1 = store, 0 = load.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data.
- rsp_valid, output, 1: response present. It is a one-cycle pulse.
- rsp_rdata, output, 32: load data. Zero for stores and errors.
- rsp_err, output, 1: misaligned or out-of-range access. Valid with rsp_valid.
- busy, output, 1: a request is in flight (state is not IDLE).

Behaviour:
- Reset: one clock edge with reset=1 sets all outputs as follows.
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Wait counter=0.
  - Memory contents are NOT cleared.
- Reset mid-operation aborts the transaction:
  - No response is issued.
  - A pending store that has not yet been committed is dropped.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, latch write, addr and wdata, and compute err. Go to WAIT if WAIT>0, else RESP.
  - WAIT: req_ready=0. The counter loads WAIT-1 on accept and decrements each cycle. At 0, go to RESP.
  - RESP:
    - Drive rsp_valid=1 for exactly one cycle.
    - A store commits to the array on this edge, only if err=0.
    - A load drives rsp_rdata = array[index], or 0 if err=1.
    - Next state is IDLE.
- req_ready is low in WAIT and RESP. Back-to-back throughput is therefore one request per WAIT+2 cycles.
- Latency from the accept edge to rsp_valid is WAIT+1 cycles. With WAIT=0, rsp_valid asserts the cycle after accept.
- Index computation:
  - offset = latched addr - BASE, computed as a 32-bit wrap-around subtract.
  - index = offset[AW_WORDS+1:2].
- Error conditions:
  - err = (offset[1:0] != 0) OR (offset >> (AW_WORDS+2) != 0).
  - This covers addresses below BASE, because the subtract wraps to a large value.
  - An errored store leaves memory unchanged.
- Request inputs are sampled only on the accept edge. Changes to req_* outside IDLE are ignored.
- rsp_rdata and rsp_err are held at their last values when rsp_valid=0. They are zeroed only by reset.
- Read-after-write: a load accepted in the cycle after a store's RESP returns the new data.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.
- No byte or halfword access; every access is a full 32-bit word.

Test Plan:
- WAIT=2, BASE=0, reset:
  - Store addr 32'h10, data 32'hDEADBEEF. Expect rsp_valid 3 cycles after accept, with rsp_err=0 and rsp_rdata=0.
  - Then load addr 32'h10. Expect rsp_rdata=32'hDEADBEEF after 3 cycles.
  - req_ready must be low for exactly 3 cycles per transaction.
- WAIT=0, BASE=0:
  - Issue four back-to-back stores to addr 0, 4, 8, 12 with data 1..4, then four loads.
  - Each response arrives 1 cycle after accept. Loads return 1, 2, 3, 4. Requests are accepted every 2 cycles.
- Misaligned store:
  - Store addr 32'h12, data 32'hFFFF_FFFF. Expect rsp_err=1.
  - A following load at 32'h10 still returns the prior value.
- BASE=32'h1000, AW_WORDS=4:
  - Load 32'h0FFC, expect err=1.
  - Load 32'h1040, expect err=1.
  - Load 32'h103C, expect err=0.
- Reset mid-WAIT (WAIT=5):
  - Accept a store to 32'h20, then assert reset 2 cycles later.
  - Expect no rsp_valid, req_ready=1 after reset, and a load at 32'h20 returning the old contents.
- Input stability:
  - Hold req_valid=1 and change req_addr during WAIT.
  - The response reflects the address latched at accept. A second request is accepted only after returning to IDLE.
